pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 36 +++
 rtl/pipe_ctrl.sv | 101 ++++++++++
 tb/tb_pipe_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline-control signal bundle: hazard/redirect requests in, hold level and PC redirect out.
// Combinational outputs; the slave side never backpressures.
interface pipe_ctrl_if;
  logic        jump_req_i;
  logic [31:0] jump_addr_i;
  logic        int_assert_i;
  logic [31:0] int_addr_i;
  logic        int_hold_req_i;
  logic        div_busy_i;
  logic        bus_hold_req_i;
  logic        exe_is_load_i;
  logic [4:0]  exe_rd_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        id_rs1_used_i;
  logic        id_rs2_used_i;
  logic [2:0]  hold_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        bus_timeout_o;
  logic [31:0] stall_cnt_o;

  modport slave (
    input  jump_req_i, jump_addr_i, int_assert_i, int_addr_i, int_hold_req_i,
           div_busy_i, bus_hold_req_i, exe_is_load_i, exe_rd_i,
           id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
    output hold_flag_o, jump_flag_o, jump_addr_o, bus_timeout_o, stall_cnt_o
  );

  modport master (
    output jump_req_i, jump_addr_i, int_assert_i, int_addr_i, int_hold_req_i,
           div_busy_i, bus_hold_req_i, exe_is_load_i, exe_rd_i,
           id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
    input  hold_flag_o, jump_flag_o, jump_addr_o, bus_timeout_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush controller with load-use detection and a bus-hold watchdog.
// Zero-latency hold/redirect decisions; watchdog grants one forward-progress cycle on timeout.
module pipe_ctrl #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    LU_STALL = 2'd2,
    RECOVER  = 2'd3
  } state_t;

  localparam logic [2:0]  HOLD_NONE = 3'd0;
  localparam logic [2:0]  HOLD_PC   = 3'd1;
  localparam logic [2:0]  HOLD_IF   = 3'd2;
  localparam logic [2:0]  HOLD_ID   = 3'd3;
  localparam logic [15:0] WD_LAST   = 16'(BUS_TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] wd_cnt;
  logic [31:0] stall_cnt;
  logic        hazard;
  logic        bus_stall;
  logic        wd_fire;
  logic [2:0]  hold;
  logic        redirect;
  logic [31:0] redirect_addr;

  always_comb begin
    hazard = bus.exe_is_load_i && (bus.exe_rd_i != 5'd0) &&
             ((bus.id_rs1_used_i && (bus.id_rs1_i == bus.exe_rd_i)) ||
              (bus.id_rs2_used_i && (bus.id_rs2_i == bus.exe_rd_i)));
  end

  // RECOVER masks the bus hold so the core always makes progress after a timeout.
  assign bus_stall = bus.bus_hold_req_i && (state != RECOVER);
  assign wd_fire   = bus_stall && (wd_cnt == WD_LAST);

  always_comb begin
    hold          = HOLD_NONE;
    redirect      = 1'b0;
    redirect_addr = 32'd0;
    state_nxt     = IDLE;
    if (bus.int_assert_i) begin
      redirect      = 1'b1;
      redirect_addr = bus.int_addr_i;
      hold          = HOLD_ID;
      state_nxt     = FLUSH;
    end else if (bus.jump_req_i) begin
      redirect      = 1'b1;
      redirect_addr = bus.jump_addr_i;
      hold          = HOLD_ID;
      state_nxt     = FLUSH;
    end else if (bus.div_busy_i || bus.int_hold_req_i) begin
      hold = HOLD_ID;
      // The stale fetch is only held here, so the pending flush must survive the stall.
      state_nxt = (state == FLUSH) ? FLUSH : IDLE;
    end else if (state == FLUSH) begin
      hold = HOLD_IF;
    end else if (bus_stall) begin
      hold = HOLD_PC;
    end else if (hazard && (state != LU_STALL)) begin
      hold      = HOLD_IF;
      state_nxt = LU_STALL;
    end
    if (wd_fire && !redirect && (state_nxt != FLUSH)) begin
      state_nxt = RECOVER;
    end
  end

  assign bus.hold_flag_o   = rst ? HOLD_NONE : hold;
  assign bus.jump_flag_o   = rst ? 1'b0 : redirect;
  assign bus.jump_addr_o   = rst ? 32'd0 : redirect_addr;
  assign bus.bus_timeout_o = rst ? 1'b0 : wd_fire;
  assign bus.stall_cnt_o   = stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wd_cnt    <= 16'd0;
      stall_cnt <= 32'd0;
    end else begin
      state <= state_nxt;
      if (!bus.bus_hold_req_i || wd_fire) begin
        wd_cnt <= 16'd0;
      end else if (bus_stall) begin
        wd_cnt <= wd_cnt + 16'd1;
      end
      if (hold != HOLD_NONE) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stimulus pushes hand-computed expectations, a negedge monitor checks them.
module tb_pipe_ctrl;

  typedef struct {
    logic        rst;
    logic        jump_req;
    logic [31:0] jump_addr;
    logic        int_assert;
    logic [31:0] int_addr;
    logic        int_hold;
    logic        div_busy;
    logic        bus_hold;
    logic        is_load;
    logic [4:0]  exe_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_used;
    logic        rs2_used;
  } stim_t;

  typedef struct {
    string       tag;
    logic [2:0]  hold;
    logic        jf;
    logic [31:0] addr;
    logic        tmo;
    logic        chk_cnt;
    logic [31:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  pipe_ctrl_if bus();

  pipe_ctrl #(.BUS_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t  q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;
  int    exp_stalls = 0;

  task automatic check(input string name, input string tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s/%s cycle=%0d actual=%h required=%h", tag, name, cyc, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("hold_flag", e.tag, 32'(bus.hold_flag_o), 32'(e.hold));
        check("jump_flag", e.tag, 32'(bus.jump_flag_o), 32'(e.jf));
        check("jump_addr", e.tag, bus.jump_addr_o, e.addr);
        check("bus_timeout", e.tag, 32'(bus.bus_timeout_o), 32'(e.tmo));
        if (e.chk_cnt) check("stall_cnt", e.tag, bus.stall_cnt_o, e.cnt);
      end
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0;      s.jump_req = 1'b0;  s.jump_addr = 32'd0;
    s.int_assert = 1'b0; s.int_addr = 32'd0; s.int_hold = 1'b0;
    s.div_busy = 1'b0; s.bus_hold = 1'b0;  s.is_load = 1'b0;
    s.exe_rd = 5'd0;   s.rs1 = 5'd0;       s.rs2 = 5'd0;
    s.rs1_used = 1'b0; s.rs2_used = 1'b0;
    return s;
  endfunction

  function automatic stim_t lu(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                               input logic [4:0] r2, input logic u2);
    stim_t s = idle();
    s.is_load = 1'b1; s.exe_rd = rd;
    s.rs1 = r1; s.rs1_used = u1; s.rs2 = r2; s.rs2_used = u2;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst                = s.rst;
    bus.jump_req_i     = s.jump_req;
    bus.jump_addr_i    = s.jump_addr;
    bus.int_assert_i   = s.int_assert;
    bus.int_addr_i     = s.int_addr;
    bus.int_hold_req_i = s.int_hold;
    bus.div_busy_i     = s.div_busy;
    bus.bus_hold_req_i = s.bus_hold;
    bus.exe_is_load_i  = s.is_load;
    bus.exe_rd_i       = s.exe_rd;
    bus.id_rs1_i       = s.rs1;
    bus.id_rs2_i       = s.rs2;
    bus.id_rs1_used_i  = s.rs1_used;
    bus.id_rs2_used_i  = s.rs2_used;
  endtask

  // Expected stall count is accumulated from the hand-written hold values, not from the DUT.
  task automatic step(input string tag, input stim_t s, input logic [2:0] hold,
                      input logic jf, input logic [31:0] addr, input logic tmo);
    exp_t e;
    @(posedge clk);
    #1;
    drive(s);
    e.tag = tag; e.hold = hold; e.jf = jf; e.addr = addr; e.tmo = tmo;
    e.chk_cnt = !s.rst;
    e.cnt = 32'(exp_stalls);
    if (s.rst) exp_stalls = 0;
    else if (hold != 3'd0) exp_stalls++;
    q.push_back(e);
  endtask

  initial begin
    stim_t s;
    drive(idle());
    rst = 1'b1;

    s = idle(); s.rst = 1'b1;
    step("rst", s, 3'd0, 1'b0, 32'd0, 1'b0);
    s.jump_req = 1'b1; s.jump_addr = 32'h100; s.int_assert = 1'b1; s.int_addr = 32'h40;
    s.div_busy = 1'b1; s.bus_hold = 1'b1;
    step("rst_forced", s, 3'd0, 1'b0, 32'd0, 1'b0);
    step("post_rst", idle(), 3'd0, 1'b0, 32'd0, 1'b0);

    s = idle(); s.jump_req = 1'b1; s.jump_addr = 32'h0000_0100;
    step("jump", s, 3'd3, 1'b1, 32'h100, 1'b0);
    step("jump_flush", idle(), 3'd2, 1'b0, 32'd0, 1'b0);
    step("jump_done", idle(), 3'd0, 1'b0, 32'd0, 1'b0);

    step("lu_hit", lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0), 3'd2, 1'b0, 32'd0, 1'b0);
    step("lu_once", lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0), 3'd0, 1'b0, 32'd0, 1'b0);
    step("lu_rd0", lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1), 3'd0, 1'b0, 32'd0, 1'b0);
    step("lu_rs2", lu(5'd7, 5'd7, 1'b0, 5'd7, 1'b1), 3'd2, 1'b0, 32'd0, 1'b0);
    step("lu_rs2_end", idle(), 3'd0, 1'b0, 32'd0, 1'b0);
    step("lu_unused", lu(5'd7, 5'd7, 1'b0, 5'd3, 1'b1), 3'd0, 1'b0, 32'd0, 1'b0);

    s = lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); s.jump_req = 1'b1; s.jump_addr = 32'h200;
    step("jump_vs_lu", s, 3'd3, 1'b1, 32'h200, 1'b0);
    step("jump_vs_lu_flush", idle(), 3'd2, 1'b0, 32'd0, 1'b0);
    step("jump_vs_lu_done", idle(), 3'd0, 1'b0, 32'd0, 1'b0);

    s = idle(); s.jump_req = 1'b1; s.jump_addr = 32'h300;
    step("jj_first", s, 3'd3, 1'b1, 32'h300, 1'b0);
    s.jump_addr = 32'h304;
    step("jj_in_flush", s, 3'd3, 1'b1, 32'h304, 1'b0);
    step("jj_flush", idle(), 3'd2, 1'b0, 32'd0, 1'b0);
    step("jj_done", idle(), 3'd0, 1'b0, 32'd0, 1'b0);

    s = idle(); s.int_assert = 1'b1; s.int_addr = 32'h8000_0040;
    s.jump_req = 1'b1; s.jump_addr = 32'h400; s.div_busy = 1'b1;
    step("prio_int", s, 3'd3, 1'b1, 32'h8000_0040, 1'b0);
    step("prio_flush", idle(), 3'd2, 1'b0, 32'd0, 1'b0);
    step("prio_done", idle(), 3'd0, 1'b0, 32'd0, 1'b0);

    s = idle(); s.div_busy = 1'b1; s.jump_req = 1'b1; s.jump_addr = 32'h500;
    step("div_jump", s, 3'd3, 1'b1, 32'h500, 1'b0);
    step("div_jump_flush", idle(), 3'd2, 1'b0, 32'd0, 1'b0);
    s = idle(); s.div_busy = 1'b1;
    step("div_only", s, 3'd3, 1'b0, 32'd0, 1'b0);
    s = idle(); s.int_hold = 1'b1;
    step("int_hold", s, 3'd3, 1'b0, 32'd0, 1'b0);
    step("hold_done", idle(), 3'd0, 1'b0, 32'd0, 1'b0);

    s = idle(); s.bus_hold = 1'b1;
    step("wd_c1", s, 3'd1, 1'b0, 32'd0, 1'b0);
    step("wd_c2", s, 3'd1, 1'b0, 32'd0, 1'b0);
    step("wd_c3", s, 3'd1, 1'b0, 32'd0, 1'b0);
    step("wd_c4", s, 3'd1, 1'b0, 32'd0, 1'b1);
    step("wd_recover", s, 3'd0, 1'b0, 32'd0, 1'b0);
    step("wd_resume", s, 3'd1, 1'b0, 32'd0, 1'b0);
    step("wd_release", idle(), 3'd0, 1'b0, 32'd0, 1'b0);
    s = lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0); s.bus_hold = 1'b1;
    step("bus_vs_lu", s, 3'd1, 1'b0, 32'd0, 1'b0);
    step("bus_vs_lu_end", idle(), 3'd0, 1'b0, 32'd0, 1'b0);

    s = idle(); s.jump_req = 1'b1; s.jump_addr = 32'h600;
    step("rf_jump", s, 3'd3, 1'b1, 32'h600, 1'b0);
    s = idle(); s.rst = 1'b1;
    step("rf_rst", s, 3'd0, 1'b0, 32'd0, 1'b0);
    step("rf_after", idle(), 3'd0, 1'b0, 32'd0, 1'b0);
    step("rf_after2", idle(), 3'd0, 1'b0, 32'd0, 1'b0);

    step("rl_hit", lu(5'd4, 5'd0, 1'b0, 5'd4, 1'b1), 3'd2, 1'b0, 32'd0, 1'b0);
    s = lu(5'd4, 5'd0, 1'b0, 5'd4, 1'b1); s.rst = 1'b1;
    step("rl_rst", s, 3'd0, 1'b0, 32'd0, 1'b0);
    step("rl_after", idle(), 3'd0, 1'b0, 32'd0, 1'b0);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d required=0 pending expectations", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
